// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
// Bundles the MEM-stage request, data-memory handshake, pipeline stall and
// error signals of the memory access controller.
//   master : pipeline / memory side (drives requests, ack, read data, err_clr)
//   slave  : the controller (drives memory request, stall, load data, flags)
interface mem_access_ctrl_if;
  // MEM-stage inputs
  logic        Mem_MemRd;
  logic        Mem_MemWr;
  logic [31:0] Mem_in;
  logic [31:0] Mem_BusB;
  // Data memory response
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        err_clr;
  // Data memory request
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  // Pipeline side results
  logic        stall;
  logic [31:0] Mem_rdata;
  logic        rd_valid;
  logic        err_timeout;
  logic        err_align;

  modport master (
    output Mem_MemRd, Mem_MemWr, Mem_in, Mem_BusB, dm_ack, dm_rdata, err_clr,
    input  dm_req, dm_we, dm_addr, dm_wdata, stall, Mem_rdata, rd_valid,
           err_timeout, err_align
  );

  modport slave (
    input  Mem_MemRd, Mem_MemWr, Mem_in, Mem_BusB, dm_ack, dm_rdata, err_clr,
    output dm_req, dm_we, dm_addr, dm_wdata, stall, Mem_rdata, rd_valid,
           err_timeout, err_align
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Turns a MEM-stage load/store into a single registered data-memory request,
// stalls the pipeline until the memory acknowledges (or a timeout expires),
// and captures load data.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : mem_access_ctrl_if.slave (MEM-stage request, memory handshake,
//           stall, load data, sticky error flags)
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_access_ctrl_if.slave     bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone, StAbort} state_e;

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            rd_valid_q, rd_valid_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_to_q, err_to_d;
  logic            err_al_q, err_al_d;
  logic            set_to, set_al;
  logic            op;

  assign op = bus.Mem_MemRd | bus.Mem_MemWr;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rd_valid_d = 1'b0;
    cnt_d      = cnt_q;
    set_to     = 1'b0;
    set_al     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (op) begin
          if (bus.Mem_in[1:0] == 2'b00) begin
            req_d   = 1'b1;
            // A simultaneous read+write request is treated as a write only
            we_d    = bus.Mem_MemWr;
            addr_d  = bus.Mem_in;
            wdata_d = bus.Mem_BusB;
            cnt_d   = '0;
            state_d = StWait;
          end else begin
            set_al  = 1'b1;
            rdata_d = '0;
            state_d = StDone;
          end
        end
      end
      StWait: begin
        if (bus.dm_ack) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          if (!we_q) begin
            rdata_d    = bus.dm_rdata;
            rd_valid_d = 1'b1;
          end
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          set_to  = 1'b1;
          rdata_d = '0;
          state_d = StAbort;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // One stall-free cycle lets the pipeline retire the instruction; the op
      // still visible here belongs to it, so it must not be reissued.
      StDone, StAbort: state_d = StIdle;
      default:         state_d = StIdle;
    endcase
    // Setting an error wins over a simultaneous clear
    err_to_d = set_to | (err_to_q & ~bus.err_clr);
    err_al_d = set_al | (err_al_q & ~bus.err_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      cnt_q      <= '0;
      err_to_q   <= 1'b0;
      err_al_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
      cnt_q      <= cnt_d;
      err_to_q   <= err_to_d;
      err_al_q   <= err_al_d;
    end
  end

  // Stall is combinational so the pipeline freezes in the cycle the op appears;
  // gated by reset so a pending op cannot stall a pipeline held in reset.
  assign bus.stall       = reset & (((state_q == StIdle) & op) | (state_q == StWait));
  assign bus.dm_req      = req_q;
  assign bus.dm_we       = we_q;
  assign bus.dm_addr     = addr_q;
  assign bus.dm_wdata    = wdata_q;
  assign bus.Mem_rdata   = rdata_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.err_timeout = err_to_q;
  assign bus.err_align   = err_al_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
// Directed self-checking bench for mem_access_ctrl (TIMEOUT = 16). Inputs are
// driven 1 ns after the rising edge and outputs sampled 1 ns later.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(
    .TIMEOUT (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;
  int stall_cnt;
  int req_cnt;
  int rises_snap;

  // Counts distinct dm_req pulses to catch duplicated accesses
  always @(negedge clk) begin
    if (bus.dm_req && !req_prev) req_rises <= req_rises + 1;
    req_prev <= bus.dm_req;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Mem_MemRd = 1'b1;  // op pending while in reset must not stall
    bus.Mem_MemWr = 1'b0;
    bus.Mem_in    = 32'h0000_0010;
    bus.Mem_BusB  = 32'h0;
    bus.dm_ack    = 1'b0;
    bus.dm_rdata  = 32'h0;
    bus.err_clr   = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    tick();
    tick();
    settle();
    check_eq("rst_stall", {31'b0, bus.stall}, 32'd0);
    check_eq("rst_req", {31'b0, bus.dm_req}, 32'd0);
    check_eq("rst_addr", bus.dm_addr, 32'h0);
    check_eq("rst_rdata", bus.Mem_rdata, 32'h0);
    check_eq("rst_flags", {29'b0, bus.rd_valid, bus.err_timeout, bus.err_align}, 32'd0);
    bus.Mem_MemRd = 1'b0;
    reset = 1'b1;
    tick();

    // Load 0x10, ack in first WAIT cycle
    bus.Mem_MemRd = 1'b1;
    bus.Mem_in    = 32'h0000_0010;
    settle();
    check_eq("ld_idle_stall", {31'b0, bus.stall}, 32'd1);
    check_eq("ld_idle_req", {31'b0, bus.dm_req}, 32'd0);
    stall_cnt = int'(bus.stall);
    tick();
    bus.dm_ack   = 1'b1;
    bus.dm_rdata = 32'hDEAD_BEEF;
    settle();
    check_eq("ld_wait_req_we", {30'b0, bus.dm_req, bus.dm_we}, 32'b10);
    check_eq("ld_wait_addr", bus.dm_addr, 32'h0000_0010);
    stall_cnt += int'(bus.stall);
    tick();
    bus.dm_ack   = 1'b0;
    bus.dm_rdata = 32'h0;
    settle();
    stall_cnt += int'(bus.stall);
    check_eq("ld_stall_cycles", stall_cnt, 32'd2);
    check_eq("ld_rdata", bus.Mem_rdata, 32'hDEAD_BEEF);
    check_eq("ld_done_valid_req", {30'b0, bus.rd_valid, bus.dm_req}, 32'b10);
    tick();
    bus.Mem_MemRd = 1'b0;
    settle();
    check_eq("ld_after_valid_req", {30'b0, bus.rd_valid, bus.dm_req}, 32'b00);

    // Store 0x20 / 0x12345678, ack in the sixth WAIT cycle
    bus.Mem_MemWr = 1'b1;
    bus.Mem_in    = 32'h0000_0020;
    bus.Mem_BusB  = 32'h1234_5678;
    settle();
    stall_cnt = int'(bus.stall);
    req_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.dm_ack = (i == 5);
      settle();
      stall_cnt += int'(bus.stall);
      if (bus.dm_req && bus.dm_we && bus.dm_addr == 32'h20 && bus.dm_wdata == 32'h1234_5678 &&
          !bus.rd_valid)
        req_cnt++;
    end
    check_eq("st_stable_cycles", req_cnt, 32'd6);
    tick();
    bus.dm_ack = 1'b0;
    settle();
    stall_cnt += int'(bus.stall);
    check_eq("st_stall_cycles", stall_cnt, 32'd7);
    check_eq("st_done_valid_req", {30'b0, bus.rd_valid, bus.dm_req}, 32'b00);
    tick();
    bus.Mem_MemWr = 1'b0;

    // Misaligned load 0x13
    bus.Mem_MemRd = 1'b1;
    bus.Mem_in    = 32'h0000_0013;
    settle();
    check_eq("al_idle_stall", {31'b0, bus.stall}, 32'd1);
    tick();
    settle();
    check_eq("al_done_stall_req", {30'b0, bus.stall, bus.dm_req}, 32'b00);
    check_eq("al_flag", {31'b0, bus.err_align}, 32'd1);
    check_eq("al_rdata", bus.Mem_rdata, 32'h0);
    check_eq("al_valid", {31'b0, bus.rd_valid}, 32'd0);
    tick();
    bus.Mem_MemRd = 1'b0;
    bus.err_clr   = 1'b1;
    settle();
    check_eq("al_sticky", {31'b0, bus.err_align}, 32'd1);
    tick();
    bus.err_clr = 1'b0;
    settle();
    check_eq("al_cleared", {31'b0, bus.err_align}, 32'd0);

    // Back-to-back store then load, both acked immediately
    rises_snap = req_rises;
    bus.Mem_MemWr = 1'b1;
    bus.Mem_in    = 32'h0000_0080;
    bus.Mem_BusB  = 32'hA5A5_A5A5;
    tick();
    bus.dm_ack = 1'b1;
    settle();
    check_eq("b2b_st_wait", {30'b0, bus.dm_req, bus.dm_we}, 32'b11);
    tick();
    bus.dm_ack = 1'b0;
    settle();
    check_eq("b2b_gap", {30'b0, bus.stall, bus.dm_req}, 32'b00);
    tick();
    bus.Mem_MemWr = 1'b0;
    bus.Mem_MemRd = 1'b1;
    bus.Mem_in    = 32'h0000_0084;
    settle();
    check_eq("b2b_ld_idle", {30'b0, bus.stall, bus.dm_req}, 32'b10);
    tick();
    bus.dm_ack   = 1'b1;
    bus.dm_rdata = 32'hCAFE_F00D;
    settle();
    check_eq("b2b_ld_wait", {30'b0, bus.dm_req, bus.dm_we}, 32'b10);
    check_eq("b2b_ld_addr", bus.dm_addr, 32'h0000_0084);
    tick();
    bus.dm_ack = 1'b0;
    settle();
    check_eq("b2b_ld_rdata", bus.Mem_rdata, 32'hCAFE_F00D);
    check_eq("b2b_ld_valid", {31'b0, bus.rd_valid}, 32'd1);
    tick();
    bus.Mem_MemRd = 1'b0;
    tick();
    check_eq("b2b_req_pulses", req_rises - rises_snap, 32'd2);

    // Ack while idle is ignored
    bus.dm_ack   = 1'b1;
    bus.dm_rdata = 32'h1111_1111;
    settle();
    check_eq("stray_ack_stall", {31'b0, bus.stall}, 32'd0);
    tick();
    bus.dm_ack = 1'b0;
    settle();
    check_eq("stray_ack_out", {30'b0, bus.dm_req, bus.rd_valid}, 32'b00);
    check_eq("stray_ack_rdata", bus.Mem_rdata, 32'hCAFE_F00D);

    // Load with no ack: 16 WAIT cycles then ABORT
    bus.Mem_MemRd = 1'b1;
    bus.Mem_in    = 32'h0000_0040;
    settle();
    req_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      settle();
      if (bus.dm_req && bus.stall) req_cnt++;
    end
    check_eq("to_wait_cycles", req_cnt, 32'd16);
    check_eq("to_flag_early", {31'b0, bus.err_timeout}, 32'd0);
    tick();
    settle();
    check_eq("to_abort_req_stall", {30'b0, bus.dm_req, bus.stall}, 32'b00);
    check_eq("to_flag", {31'b0, bus.err_timeout}, 32'd1);
    check_eq("to_rdata", bus.Mem_rdata, 32'h0);
    check_eq("to_valid", {31'b0, bus.rd_valid}, 32'd0);
    tick();
    bus.Mem_MemRd = 1'b0;
    settle();
    check_eq("to_idle_stall", {31'b0, bus.stall}, 32'd0);

    // Misaligned op with err_clr in the same cycle: set beats clear
    bus.Mem_MemRd = 1'b1;
    bus.Mem_in    = 32'h0000_0041;
    bus.err_clr   = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    settle();
    check_eq("prio_flags", {30'b0, bus.err_timeout, bus.err_align}, 32'b01);
    tick();
    bus.Mem_MemRd = 1'b0;

    // Reset in the second WAIT cycle
    bus.Mem_MemRd = 1'b1;
    bus.Mem_in    = 32'h0000_0100;
    tick();
    tick();
    settle();
    check_eq("rw_wait2_req", {31'b0, bus.dm_req}, 32'd1);
    reset = 1'b0;
    settle();
    check_eq("rw_req_drop", {30'b0, bus.dm_req, bus.stall}, 32'b00);
    check_eq("rw_addr", bus.dm_addr, 32'h0);
    check_eq("rw_rdata_flags", {bus.Mem_rdata[28:0], bus.err_timeout, bus.err_align, bus.rd_valid},
             32'h0);
    bus.Mem_MemRd = 1'b0;
    tick();
    reset = 1'b1;
    rises_snap = req_rises;
    req_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      if (bus.dm_req || bus.stall) req_cnt++;
    end
    check_eq("rw_no_reissue", req_cnt, 32'd0);
    check_eq("rw_no_pulse", req_rises - rises_snap, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum WAIT cycles before abort (range 2..255).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; low forces reset state immediately, independent of clk.
REQ-004 Mem_MemRd  in  1  MEM-stage load request from the EX/MEM pipeline register.
REQ-005 Mem_MemWr  in  1  MEM-stage store request from the EX/MEM pipeline register.
REQ-006 Mem_in  in  32  MEM-stage ALU result, used as the byte address.
REQ-007 Mem_BusB  in  32  MEM-stage store data.
REQ-008 dm_ack  in  1  data memory completion strobe.
REQ-009 dm_rdata  in  32  data memory read data; valid when dm_ack=1.
REQ-010 err_clr  in  1  synchronous clear of the sticky error flags.
REQ-011 dm_req  out  1  registered memory request.
REQ-012 dm_we  out  1  registered write enable; qualified by dm_req.
REQ-013 dm_addr  out  32  registered address.
REQ-014 dm_wdata  out  32  registered write data.
REQ-015 stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM registers.
REQ-016 Mem_rdata  out  32  captured load data.
REQ-017 rd_valid  out  1  one-cycle strobe marking Mem_rdata valid.
REQ-018 err_timeout, err_align  out  1 each  sticky error flags.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, WAIT, DONE, ABORT.
REQ-020 op = Mem_MemRd | Mem_MemWr; when both are high, the access SHALL be a write and no read SHALL occur.
REQ-021 IDLE, op=0: stall=0; FSM remains in IDLE.
REQ-022 IDLE, op=1, Mem_in[1:0]=00: stall=1 combinationally; at the next edge, dm_req=1, dm_we=Mem_MemWr, dm_addr=Mem_in, dm_wdata=Mem_BusB, counter=0, FSM goes to WAIT.
REQ-023 IDLE, op=1, Mem_in[1:0]!=00: stall=1; no dm_req; at the next edge, err_align=1 and FSM goes to DONE with Mem_rdata=0.
REQ-024 WAIT: stall=1; dm_req, dm_we, dm_addr and dm_wdata SHALL be held stable until dm_ack is sampled high.
REQ-025 WAIT, dm_ack=1: at the next edge, dm_req=0; for a read, Mem_rdata=dm_rdata; FSM goes to DONE.
REQ-026 WAIT, dm_ack=0: the counter SHALL increment; at counter=TIMEOUT-1, the next edge SHALL set dm_req=0, err_timeout=1, Mem_rdata=0, and move FSM to ABORT.
REQ-027 DONE and ABORT: stall=0 for exactly one cycle; the next edge returns FSM to IDLE.
REQ-028 rd_valid SHALL be 1 only in a DONE cycle that followed a successful read; it SHALL be 0 in ABORT.
REQ-029 An op present in the cycle after DONE/ABORT is a new instruction and SHALL be started from IDLE; an access SHALL never be issued twice.
REQ-030 dm_ack outside WAIT SHALL be ignored.
REQ-031 Minimum latency: op seen in cycle N, ack in cycle N+1, stall=0 in cycle N+2 (2 stall cycles).
REQ-032 err_clr=1 SHALL clear both flags at the edge; a simultaneous set event SHALL take priority over the clear.
REQ-033 The counter SHALL be $clog2(TIMEOUT) bits wide, SHALL saturate, and SHALL never wrap.

Reset
REQ-034 reset=0 SHALL force: state=IDLE; dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0; Mem_rdata=0; rd_valid=0; counter=0; err_timeout=0, err_align=0.
REQ-035 stall SHALL be 0 while reset=0.
REQ-036 Reset asserted during WAIT SHALL drop dm_req asynchronously, and the aborted access SHALL not be reissued after release.

Verification
REQ-037 Load 0x00000010, dm_ack in the cycle after dm_req rises, dm_rdata=0xDEADBEEF -> stall high for 2 cycles; Mem_rdata=0xDEADBEEF; rd_valid pulses once.
REQ-038 Store 0x00000020, data 0x12345678, ack after 5 WAIT cycles -> dm_we=1 and address/data stable throughout; rd_valid=0; stall high for 7 cycles.
REQ-039 Load 0x00000013 -> no dm_req; err_align=1; stall high for 1 cycle; err_clr then clears err_align.
REQ-040 Load with dm_ack never asserted, TIMEOUT=16 -> after 16 WAIT cycles dm_req=0, err_timeout=1, FSM passes through ABORT, Mem_rdata=0.
REQ-041 Back-to-back store then load, each acked immediately -> two distinct dm_req pulses; one stall-free cycle between them; no duplicate access.
REQ-042 reset pulled low in the second WAIT cycle -> dm_req=0 immediately; all outputs at reset values; no request after release until a new op arrives.
